rtc_timer: RTL and testbench

Memory-mapped real-time timer: a 64-bit `mtime` counter advanced by a prescaled RTC tick derived from the system clock, plus `CHANNELS` independent 64-bit compare registers, each driving a level interrupt. The block sits on the core's peripheral bus in the timer address window. It generalises the single-comparator timer to a parameterised clock ratio, channel count and base address, and adds a runtime enable.

---
 rtl/rtc_timer.sv | 136 +++++++++++++
 tb/tb_rtc_timer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rtc_timer.sv
// Bus-mapped 64-bit real-time counter with a prescaled tick and CHANNELS compare interrupts.
// Single-cycle request, response one cycle later; irq is registered from start-of-cycle state.
module rtc_timer #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned RTC_FREQ  = 32768,
  parameter int unsigned CHANNELS  = 2,
  parameter logic [31:0] BASE_ADDR = 32'h200000
) (
  input  logic                rst,
  input  logic                clk,
  input  logic                timer_valid,
  input  logic [31:0]         timer_addr,
  input  logic [31:0]         timer_wdata,
  input  logic [3:0]          timer_wstrb,
  output logic [31:0]         timer_rdata,
  output logic                timer_ready,
  output logic [CHANNELS-1:0] timer_irq
);

  localparam int unsigned DIV = CLK_FREQ / RTC_FREQ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [31:0] WIN = 32'(16 + 8 * CHANNELS);

  logic [PW-1:0]       r_pcnt;
  logic                r_en;
  logic [63:0]         r_mtime;
  logic [63:0]         r_cmp [CHANNELS];
  logic [CHANNELS-1:0] r_irq;
  logic                r_ready;
  logic [31:0]         r_rdata;

  logic        w_tick;
  logic [31:0] w_off;
  logic        w_hit;
  logic [3:0]  w_widx;
  logic        w_wr;
  logic        w_wr_lo;
  logic        w_wr_hi;
  logic        w_wr_ctrl;
  logic [63:0] w_mtime_inc;
  logic [31:0] w_rval;

  function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) res[8*b +: 8] = d[8*b +: 8];
    return res;
  endfunction

  assign w_tick      = r_en && (r_pcnt == PW'(DIV - 1));
  assign w_mtime_inc = r_mtime + 64'd1;

  // Aligned base means bits [1:0] cannot change the window or word-index decode.
  assign w_off     = timer_addr - BASE_ADDR;
  assign w_hit     = (timer_addr >= BASE_ADDR) && (w_off < WIN);
  assign w_widx    = w_off[5:2];
  assign w_wr      = timer_valid && (timer_wstrb != 4'b0) && w_hit;
  assign w_wr_lo   = w_wr && (w_widx == 4'd0);
  assign w_wr_hi   = w_wr && (w_widx == 4'd1);
  assign w_wr_ctrl = w_wr && (w_widx == 4'd2);

  always_comb begin
    w_rval = 32'h0;
    if (w_hit) begin
      case (w_widx)
        4'd0:    w_rval = r_mtime[31:0];
        4'd1:    w_rval = r_mtime[63:32];
        4'd2:    w_rval = {31'h0, r_en};
        default: begin
          for (int i = 0; i < int'(CHANNELS); i++) begin
            if (w_widx == 4'(4 + 2 * i)) w_rval = r_cmp[i][31:0];
            if (w_widx == 4'(5 + 2 * i)) w_rval = r_cmp[i][63:32];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt <= '0;
      r_en   <= 1'b1;
    end else begin
      if (r_en) r_pcnt <= w_tick ? '0 : r_pcnt + PW'(1);
      if (w_wr_ctrl && timer_wstrb[0]) r_en <= timer_wdata[0];
    end
  end

  // A write to either half wins over a coincident tick; the other half gets no carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtime <= 64'h0;
    end else begin
      if (w_wr_lo)
        r_mtime[31:0] <= f_merge(r_mtime[31:0], timer_wdata, timer_wstrb);
      else if (w_tick && !w_wr_hi)
        r_mtime[31:0] <= w_mtime_inc[31:0];
      if (w_wr_hi)
        r_mtime[63:32] <= f_merge(r_mtime[63:32], timer_wdata, timer_wstrb);
      else if (w_tick && !w_wr_lo)
        r_mtime[63:32] <= w_mtime_inc[63:32];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(CHANNELS); i++) r_cmp[i] <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_irq <= '0;
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (w_wr && (w_widx == 4'(4 + 2 * i)))
          r_cmp[i][31:0] <= f_merge(r_cmp[i][31:0], timer_wdata, timer_wstrb);
        if (w_wr && (w_widx == 4'(5 + 2 * i)))
          r_cmp[i][63:32] <= f_merge(r_cmp[i][63:32], timer_wdata, timer_wstrb);
        r_irq[i] <= (r_mtime >= r_cmp[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      r_ready <= timer_valid;
      r_rdata <= (timer_valid && (timer_wstrb == 4'b0)) ? w_rval : 32'h0;
    end
  end

  assign timer_ready = r_ready;
  assign timer_rdata = r_rdata;
  assign timer_irq   = r_irq;

endmodule

// File: tb/tb_rtc_timer.sv
// Bench for rtc_timer: scheduled bus reads against edge-exact expected values, a response
// scoreboard, table-driven register vectors and hand-written tick/irq/reset sequences.
module tb_rtc_timer;
  localparam int          CH   = 2;
  localparam logic [31:0] BASE = 32'h200000;

  logic          rst = 1'b1;
  logic          clk = 1'b0;
  logic          timer_valid = 1'b0;
  logic [31:0]   timer_addr  = 32'h0;
  logic [31:0]   timer_wdata = 32'h0;
  logic [3:0]    timer_wstrb = 4'h0;
  logic [31:0]   timer_rdata;
  logic          timer_ready;
  logic [CH-1:0] timer_irq;

  rtc_timer #(
    .CLK_FREQ(50000000), .RTC_FREQ(32768), .CHANNELS(CH), .BASE_ADDR(BASE)
  ) dut (
    .rst(rst), .clk(clk), .timer_valid(timer_valid), .timer_addr(timer_addr),
    .timer_wdata(timer_wdata), .timer_wstrb(timer_wstrb), .timer_rdata(timer_rdata),
    .timer_ready(timer_ready), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  typedef struct { string name; logic [31:0] val; } exp_t;
  typedef struct { string name; logic [31:0] off; logic [31:0] wd; logic [3:0] ws; logic [31:0] exp; } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc;
  logic exp_rdy;
  logic watch = 1'b0;
  logic irq_bad = 1'b0;
  exp_t q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Edge counter since reset release, and the response each edge must produce.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc     <= 0;
      exp_rdy <= 1'b0;
    end else begin
      cyc     <= cyc + 1;
      exp_rdy <= timer_valid;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (watch && (timer_irq != '0)) irq_bad = 1'b1;
    if (exp_rdy || timer_ready) begin
      check("ready_timing", {63'h0, timer_ready}, {63'h0, exp_rdy});
      if (exp_rdy && timer_ready) begin
        if (q.size() == 0) begin
          fails++;
          $display("FAIL scoreboard: response with no expected entry at cycle %0d", cyc);
        end else begin
          e = q.pop_front();
          check(e.name, {32'h0, timer_rdata}, {32'h0, e.val});
        end
      end
    end
  end

  task automatic req(input string name, input logic [31:0] off, input logic [31:0] wd,
                     input logic [3:0] ws, input logic [31:0] exp);
    exp_t e;
    timer_valid = 1'b1;
    timer_addr  = BASE + off;
    timer_wdata = wd;
    timer_wstrb = ws;
    e.name = name;
    e.val  = (ws != 4'h0) ? 32'h0 : exp;
    q.push_back(e);
    @(negedge clk);
    timer_valid = 1'b0;
    timer_wstrb = 4'h0;
  endtask

  // Returns at the negedge just before edge k, so a request issued next is sampled at edge k.
  task automatic go_to(input int k);
    while (cyc < k - 1) @(negedge clk);
    if (cyc != k - 1) begin
      fails++;
      $display("FAIL schedule: at cycle %0d, wanted %0d", cyc, k - 1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[14];
    tbl[0]  = '{"cmp0_lo_wr_strb",  32'h10,        32'hAABBCCDD, 4'b0101, 32'h0};
    tbl[1]  = '{"cmp0_lo_rd",       32'h10,        32'h0,        4'b0000, 32'hFFBBFFDD};
    tbl[2]  = '{"cmp0_hi_rd",       32'h14,        32'h0,        4'b0000, 32'hFFFFFFFF};
    tbl[3]  = '{"ctrl_rd",          32'h08,        32'h0,        4'b0000, 32'h1};
    tbl[4]  = '{"ctrl_wr_no_byte0", 32'h08,        32'h0,        4'b0010, 32'h0};
    tbl[5]  = '{"ctrl_rd_kept",     32'h08,        32'h0,        4'b0000, 32'h1};
    tbl[6]  = '{"rsvd_wr",          32'h0C,        32'h12345678, 4'b1111, 32'h0};
    tbl[7]  = '{"rsvd_rd",          32'h0C,        32'h0,        4'b0000, 32'h0};
    tbl[8]  = '{"past_window_rd",   32'h20,        32'h0,        4'b0000, 32'h0};
    tbl[9]  = '{"below_base_rd",    32'hFFFFFFFC,  32'h0,        4'b0000, 32'h0};
    tbl[10] = '{"cmp1_hi_wr_strb",  32'h1C,        32'h00000002, 4'b0011, 32'h0};
    tbl[11] = '{"cmp1_hi_rd",       32'h1C,        32'h0,        4'b0000, 32'h2};
    tbl[12] = '{"cmp1_lo_rd_a11",   32'h1B,        32'h0,        4'b0000, 32'h5};
    tbl[13] = '{"cmp1_lo_rd",       32'h18,        32'h0,        4'b0000, 32'h5};

    repeat (3) @(negedge clk);
    check("rst_ready", {63'h0, timer_ready}, 64'h0);
    check("rst_rdata", {32'h0, timer_rdata}, 64'h0);
    check("rst_irq",   {62'h0, timer_irq},   64'h0);
    rst   = 1'b0;
    watch = 1'b1;

    // Tick period: mtime steps exactly every 1525 edges.
    go_to(1525); req("mtime_at_1525", 32'h00, 32'h0, 4'h0, 32'd0);
    req("mtime_at_1526", 32'h00, 32'h0, 4'h0, 32'd1);
    go_to(3050); req("mtime_at_3050", 32'h00, 32'h0, 4'h0, 32'd1);
    req("mtime_at_3051", 32'h00, 32'h0, 4'h0, 32'd2);
    @(negedge clk);
    watch = 1'b0;
    check("irq_quiet_phase_a", {63'h0, irq_bad}, 64'h0);

    // Compare channel 1 at 5: tick to 5 happens at edge 7625.
    go_to(3060);
    req("cmp1_lo_wr", 32'h18, 32'd5, 4'hF, 32'h0);
    req("cmp1_hi_wr", 32'h1C, 32'd0, 4'hF, 32'h0);
    go_to(7626);
    check("irq_before_rise", {62'h0, timer_irq}, 64'h0);
    @(negedge clk);
    check("irq1_rise", {62'h0, timer_irq}, 64'h2);
    go_to(7630);
    req("cmp1_hi_raise", 32'h1C, 32'd1, 4'hF, 32'h0);
    check("irq1_held", {62'h0, timer_irq}, 64'h2);
    @(negedge clk);
    check("irq1_fall", {62'h0, timer_irq}, 64'h0);

    // Write to mtime lo in the same cycle as the tick at edge 9150.
    go_to(9150);
    req("mtime_lo_wr_tick", 32'h00, 32'hFFFFFFFF, 4'hF, 32'h0);
    req("coll_lo", 32'h00, 32'h0, 4'h0, 32'hFFFFFFFF);
    req("coll_hi", 32'h04, 32'h0, 4'h0, 32'h0);
    go_to(10675);
    req("pre_wrap_lo", 32'h00, 32'h0, 4'h0, 32'hFFFFFFFF);
    req("wrap_lo",     32'h00, 32'h0, 4'h0, 32'h0);
    req("wrap_hi",     32'h04, 32'h0, 4'h0, 32'h1);
    check("irq_after_wrap", {62'h0, timer_irq}, 64'h0);

    go_to(10700);
    for (int i = 0; i < 14; i++) req(tbl[i].name, tbl[i].off, tbl[i].wd, tbl[i].ws, tbl[i].exp);

    // Enable gating: pcnt frozen at 325 from edge 11000 to 16000, next tick at 17200.
    go_to(11000);
    req("ctrl_wr_0", 32'h08, 32'h0, 4'h1, 32'h0);
    req("ctrl_rd_0", 32'h08, 32'h0, 4'h0, 32'h0);
    go_to(12201); req("frozen_12201", 32'h00, 32'h0, 4'h0, 32'h0);
    go_to(15990); req("frozen_15990", 32'h00, 32'h0, 4'h0, 32'h0);
    go_to(16000); req("ctrl_wr_1", 32'h08, 32'h1, 4'hF, 32'h0);
    go_to(17200); req("resume_17200", 32'h00, 32'h0, 4'h0, 32'h0);
    req("resume_17201", 32'h00, 32'h0, 4'h0, 32'h1);
    req("resume_hi",    32'h04, 32'h0, 4'h0, 32'h1);
    go_to(18725); req("period_18725", 32'h00, 32'h0, 4'h0, 32'h1);
    req("period_18726", 32'h00, 32'h0, 4'h0, 32'h2);

    // Unmapped reads, then arm irq[0] and reset in the middle of a response.
    go_to(18730);
    req("unmapped_0C", 32'h0C, 32'h0, 4'h0, 32'h0);
    req("unmapped_40", 32'h40, 32'h0, 4'h0, 32'h0);
    req("cmp0_hi_zero", 32'h14, 32'h0, 4'hF, 32'h0);
    req("cmp0_lo_zero", 32'h10, 32'h0, 4'hF, 32'h0);
    go_to(18736);
    check("irq0_set", {62'h0, timer_irq}, 64'h1);
    go_to(18740);
    timer_valid = 1'b1;
    timer_addr  = BASE;
    timer_wstrb = 4'h0;
    @(posedge clk);
    #1;
    check("ready_before_rst", {63'h0, timer_ready}, 64'h1);
    #1;
    rst = 1'b1;
    timer_valid = 1'b0;
    #1;
    check("rst_async_ready", {63'h0, timer_ready}, 64'h0);
    check("rst_async_rdata", {32'h0, timer_rdata}, 64'h0);
    check("rst_async_irq",   {62'h0, timer_irq},   64'h0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    req("post_rst_cmp0_lo", 32'h10, 32'h0, 4'h0, 32'hFFFFFFFF);
    req("post_rst_cmp1_hi", 32'h1C, 32'h0, 4'h0, 32'hFFFFFFFF);
    req("post_rst_ctrl",    32'h08, 32'h0, 4'h0, 32'h1);
    req("post_rst_lo",      32'h00, 32'h0, 4'h0, 32'h0);
    req("post_rst_hi",      32'h04, 32'h0, 4'h0, 32'h0);
    go_to(1526); req("post_rst_tick", 32'h00, 32'h0, 4'h0, 32'h1);
    check("post_rst_irq", {62'h0, timer_irq}, 64'h0);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d responses missing", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
